// File: rtl/usb_status_pio_if.sv
// Avalon-MM slave bus bundle for the USB status input PIO.
interface usb_status_pio_if;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/usb_status_pio_in.sv
// USB controller status input PIO: synchronise, debounce, capture edges into a
// write-1-to-clear register and raise a maskable level interrupt.
module usb_status_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    usb_status_pio_if.slave     bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic             r_irq;

    logic             w_wr;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edgecap_next;
    logic [WIDTH-1:0] w_mask_next;
    logic             w_unused_wdata;

    // Two-flop synchroniser and per-bit saturating debounce counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= in_port;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= CW'(r_cnt[i] + CW'(1));
                end
            end
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            w_edge = r_stable & ~r_stable_d;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~r_stable & r_stable_d;
        end else begin
            w_edge = r_stable ^ r_stable_d;
        end
    end

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_clr          = (w_wr && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;
    // A fresh edge overrides a simultaneous clear of the same bit
    assign w_edgecap_next = (r_edgecap & ~w_clr) | w_edge;
    assign w_mask_next    = (w_wr && (bus.address == 2'd2)) ? bus.writedata[WIDTH-1:0] : r_mask;
    assign w_unused_wdata = &{1'b0, bus.writedata};

    // irq is a flop fed from the next-state values so it tracks the registers without lag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask    <= '0;
            r_edgecap <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_mask    <= w_mask_next;
            r_edgecap <= w_edgecap_next;
            r_irq     <= |(w_edgecap_next & w_mask_next);
        end
    end

    assign irq = r_irq;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = 32'(r_stable);
            2'd2:    bus.readdata = 32'(r_mask);
            2'd3:    bus.readdata = 32'(r_edgecap);
            default: bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_usb_status_pio_in.sv
// Directed and randomized bench for usb_status_pio_in (rising-edge and any-edge instances).
module tb_usb_status_pio_in;
    localparam int unsigned W = 4;
    localparam int unsigned D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [1:0]    d_addr;
    logic          d_cs;
    logic          d_wn;
    logic [31:0]   d_wd;
    logic [W-1:0]  d_in;
    logic          irq0;
    logic          irq1;

    usb_status_pio_if bus0 ();
    usb_status_pio_if bus1 ();

    assign bus0.address    = d_addr;
    assign bus0.chipselect = d_cs;
    assign bus0.write_n    = d_wn;
    assign bus0.writedata  = d_wd;
    assign bus1.address    = d_addr;
    assign bus1.chipselect = d_cs;
    assign bus1.write_n    = d_wn;
    assign bus1.writedata  = d_wd;

    usb_status_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(d_in), .irq(irq0));
    usb_status_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(d_in), .irq(irq1));

    // Reference model: stable flips once the last D synchronised samples all disagree with it
    logic [W-1:0] m_s1, m_s2, m_st, m_sd, m_mask;
    logic [W-1:0] m_ec [2];
    logic [W-1:0] m_hist [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_sd = '0; m_mask = '0;
        m_ec[0] = '0; m_ec[1] = '0;
        m_hist.delete();
    endfunction

    function automatic logic [31:0] m_rd(input int k, input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_st);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_ec[k]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge();
        logic [W-1:0] clr, nst;
        logic         all_diff;
        if (!reset_n) begin
            model_reset();
            return;
        end
        clr = (d_cs && !d_wn && d_addr == 2'd3) ? d_wd[W-1:0] : '0;
        m_ec[0] = (m_ec[0] & ~clr) | (m_st & ~m_sd);
        m_ec[1] = (m_ec[1] & ~clr) | (m_st ^ m_sd);
        if (d_cs && !d_wn && d_addr == 2'd2) m_mask = d_wd[W-1:0];
        m_hist.push_back(m_s2);
        if (m_hist.size() > int'(D)) void'(m_hist.pop_front());
        nst = m_st;
        if (m_hist.size() == int'(D)) begin
            for (int b = 0; b < int'(W); b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(D); j++) begin
                    if (m_hist[j][b] == m_st[b]) all_diff = 1'b0;
                end
                if (all_diff) nst[b] = ~m_st[b];
            end
        end
        m_sd = m_st;
        m_st = nst;
        m_s2 = m_s1;
        m_s1 = d_in;
    endfunction

    task automatic check_all();
        chk("model_rd_rise", bus0.readdata, m_rd(0, d_addr));
        chk("model_rd_any",  bus1.readdata, m_rd(1, d_addr));
        chk("model_irq_rise", 32'(irq0), 32'(|(m_ec[0] & m_mask)));
        chk("model_irq_any",  32'(irq1), 32'(|(m_ec[1] & m_mask)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic peek(input logic [1:0] a);
        d_addr = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        d_cs = 1'b1; d_wn = 1'b0; d_addr = a; d_wd = data;
        step();
        d_cs = 1'b0; d_wn = 1'b1;
    endtask

    int hold;

    initial begin
        reset_n = 1'b0;
        d_addr = 2'd0; d_cs = 1'b0; d_wn = 1'b1; d_wd = '0; d_in = '0;
        model_reset();
        #1;

        // Reset state
        peek(2'd0); chk("reset_addr0", bus0.readdata, 32'h0);
        peek(2'd2); chk("reset_addr2", bus0.readdata, 32'h0);
        peek(2'd3); chk("reset_addr3", bus0.readdata, 32'h0);
        chk("reset_irq", 32'(irq0), 32'h0);
        step(); step();
        reset_n = 1'b1;

        // Rising edge latency and mask enable
        d_addr = 2'd0;
        d_in   = 4'b0001;
        repeat (17) step();
        peek(2'd0); chk("rise_before_18", bus0.readdata, 32'h0);
        step();
        peek(2'd0); chk("rise_stable_18", bus0.readdata, 32'h1);
        peek(2'd3); chk("rise_cap_not_yet", bus0.readdata, 32'h0);
        step();
        peek(2'd3); chk("rise_cap_19", bus0.readdata, 32'h1);
        chk("rise_irq_masked", 32'(irq0), 32'h0);
        wr(2'd2, 32'h1);
        chk("rise_irq_enabled", 32'(irq0), 32'h1);

        // Glitch rejection, then a long-enough pulse
        d_in = 4'b0011;
        repeat (10) step();
        d_in = 4'b0001;
        repeat (20) step();
        peek(2'd0); chk("glitch_stable", bus0.readdata, 32'h1);
        peek(2'd3); chk("glitch_cap", bus0.readdata, 32'h1);
        d_in = 4'b0011;
        repeat (18) step();
        peek(2'd0); chk("long_pulse_stable", bus0.readdata, 32'h3);
        step();
        peek(2'd3); chk("long_pulse_cap", bus0.readdata, 32'h3);

        // Write-1-to-clear and masking
        wr(2'd2, 32'h2);
        wr(2'd3, 32'h1);
        peek(2'd3); chk("w1c_partial", bus0.readdata, 32'h2);
        chk("w1c_irq_held", 32'(irq0), 32'h1);
        wr(2'd2, 32'h1);
        chk("mask_irq_drop", 32'(irq0), 32'h0);

        // Clear colliding with a fresh edge on the same bit
        d_in = 4'b0010;
        repeat (19) step();
        peek(2'd0); chk("fall_stable", bus0.readdata, 32'h2);
        d_in = 4'b0011;
        repeat (18) step();
        d_cs = 1'b1; d_wn = 1'b0; d_addr = 2'd3; d_wd = 32'h1;
        step();
        d_cs = 1'b0; d_wn = 1'b1;
        peek(2'd3); chk("collision_set_wins", bus0.readdata, 32'h3);

        // Any-edge capture on bit 3, and the reserved address
        wr(2'd2, 32'hF);
        wr(2'd3, 32'hF);
        d_in = 4'b1011;
        repeat (20) step();
        peek(2'd3); chk("any_rise_cap", bus1.readdata, 32'h8);
        wr(2'd3, 32'hF);
        peek(2'd3); chk("any_cleared", bus1.readdata, 32'h0);
        chk("any_irq_cleared", 32'(irq1), 32'h0);
        d_in = 4'b0011;
        repeat (20) step();
        peek(2'd3); chk("any_fall_cap", bus1.readdata, 32'h8);
        chk("any_fall_irq", 32'(irq1), 32'h1);
        chk("rise_ignores_fall", bus0.readdata, 32'h0);
        chk("rise_irq_low", 32'(irq0), 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        peek(2'd1); chk("addr1_reads0_any", bus1.readdata, 32'h0);
        chk("addr1_reads0_rise", bus0.readdata, 32'h0);
        peek(2'd0); chk("addr1_no_effect", bus1.readdata, 32'h3);

        // Randomized traffic against the model, with one reset mid-debounce
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                d_in = W'($urandom);
                hold = int'($urandom_range(1, 24));
            end
            hold--;
            if ($urandom_range(0, 7) == 0) begin
                d_cs = 1'b1; d_wn = 1'b0;
                d_addr = 2'($urandom); d_wd = $urandom;
            end else begin
                d_cs = 1'($urandom); d_wn = 1'b1;
                d_addr = 2'($urandom); d_wd = $urandom;
            end
            if (i == 1500) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                check_all();
                step(); step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
